drive_cmd_arbiter: RTL
======================

# drive_cmd_arbiter

Parametrised drive controller for the car. It decodes Zigbee command bytes into an operating mode and owns the motor speed, steering degree and direction outputs. It adds three protections to the drive path: rate-limited speed changes, direction reversal only at zero speed, and a command-loss watchdog. It sits between the Zigbee receiver, the ultrasonic and infrared sensor front-ends, and the motor PWM and servo drivers.

## Interface
- SPEED_W, 8, width of speed paths
- DEG_W, 9, width of degree output
- DEG_CENTER, 95, straight-ahead servo degree
- DEG_LEFT, 60, full-left degree; tracker index 0
- DEG_RIGHT, 120, full-right degree; tracker index N_TRACK-1
- N_TRACK, 4, number of downward line sensors, ≥2
- SAFE_DIST, 20, forward distance at or below which forward motion is forbidden
- RAMP_DIV, 500000, clk_50M cycles per speed slew tick
- RAMP_STEP, 1, speed change per slew tick
- TIMEOUT_CYC, 25000000, REMOTE-mode command timeout in cycles

Ports:
- clk_50M  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- rx_valid  in  1  one-cycle strobe; rx_data holds a new byte
- rx_data  in  8  command byte
- button  in  SPEED_W  default cruise speed, used until a cruise command arrives
- forward_dist  in  8  front ultrasonic distance
- track  in  N_TRACK  line sensors; 1 = on black line
- speed  out  SPEED_W  motor speed magnitude
- degree  out  DEG_W  servo degree
- direction  out  1  1 = forward, 0 = reverse
- beep_en  out  1  buzzer enable
- mode  out  2  0 IDLE, 1 REMOTE, 2 TRACK, 3 ROAM
- timeout  out  1  sticky watchdog flag
- obstacle  out  1  forward motion blocked this cycle

## Operation
- Command decode happens only on rx_valid, using rx_data[7:6]:
  - 00 REMOTE: mode←REMOTE.
    - [1:0] speed code: 00/11 = 0, 01 = cruise>>1, 10 = cruise.
    - [3:2] steer: 01 = DEG_LEFT, 10 = DEG_RIGHT, else DEG_CENTER.
    - [4] requested direction: 0 = forward, 1 = reverse.
  - 01 CRUISE: cruise←{0,rx_data[5:0]}; cruise_set←1. Mode is unchanged.
  - 10 FUNCTION: [1:0] selects 00 TRACK, 01 ROAM, 10 IDLE; 11 is ignored.
  - 11 E-STOP: mode←IDLE, target←0, speed←0 immediately, bypassing the ramp.
- Effective cruise = cruise_set ? cruise : button.
- Target speed and degree per mode:
  - IDLE: target 0, degree DEG_CENTER.
  - REMOTE: target and degree as decoded.
  - ROAM: target = cruise, degree DEG_CENTER, forward.
  - TRACK, forward only:
    - all track bits 0: degree DEG_CENTER, target = cruise.
    - all bits 1: target 0, degree held.
    - otherwise: degree = DEG_LEFT + i·((DEG_RIGHT−DEG_LEFT)/(N_TRACK−1)), where i is the lowest set index. Integer step is computed at elaboration. Target = cruise.
- Slew control:
  - A prescaler counts 0..RAMP_DIV−1 and ticks on wrap.
  - On each tick, speed moves RAMP_STEP toward target and never overshoots; it is clamped to target.
- Direction reversal:
  - If the requested direction ≠ direction, the effective target is 0.
  - direction flips in the first cycle where speed==0.
  - Ramp-up in the new direction follows on later ticks.
- Obstacle: obstacle = direction && forward_dist ≤ SAFE_DIST. While it is set, speed←0 immediately and the ramp is held. Reverse motion is unaffected.
- Watchdog:
  - The counter clears on every rx_valid and counts only in REMOTE.
  - At TIMEOUT_CYC it sets mode←IDLE and timeout←1.
  - timeout clears on the next rx_valid.
- beep_en = obstacle | (!direction && speed≠0).

## Timing
- Reset values:
  - speed 0, degree DEG_CENTER, direction 1, mode IDLE
  - beep_en 0, timeout 0, obstacle 0
  - cruise 0, cruise_set 0, prescaler and watchdog counters 0
- All outputs are registered.
- Command latency: rx_valid sampled at edge N → mode, degree and targets valid after edge N+1. Speed changes no earlier than the next ramp tick; E-STOP is the exception.
- Obstacle: forward_dist sampled at edge N → speed 0 and obstacle 1 after edge N+1. Ramp resumes on the first tick after clearance.
- Same-cycle events:
  - E-STOP with obstacle: both force 0.
  - rx_valid with watchdog expiry: the command wins and the counter clears.
  - Tick with a reverse request: speed steps toward 0.
- A reset asserted mid-ramp or mid-reversal returns everything to reset values on the next edge.
- Invalid FUNCTION code 11: no state change, but the watchdog still clears.

## Test plan
Bench parameters: RAMP_DIV=4, RAMP_STEP=1, TIMEOUT_CYC=100, N_TRACK=4.
- CRUISE 0x4A, then REMOTE 0x02 → cruise=10; speed rises 1 per 4 cycles to 10; direction=1; degree=95.
- At speed 10, REMOTE 0x12 (reverse) → speed ramps to 0; direction=0 at the zero cycle; speed climbs to 10; beep_en=1 while reversing.
- REMOTE forward at speed 10, forward_dist=20 → speed=0 and obstacle=1 one cycle later. forward_dist=21 → ramp restarts from 0.
- REMOTE forward, then no rx_valid for 100 cycles → mode=0, timeout=1, speed ramps to 0. Next byte clears timeout.
- FUNCTION 0x80 (TRACK) → track=0100: degree=100; track=0000: degree=95; track=1111: target 0.
- Mid-ramp at speed 6, E-STOP 0xC0 → speed=0, mode=0 the next cycle. rst_n low one edge → all outputs at reset values.

Source files
------------

// File: rtl/drive_cmd_arbiter_if.sv
// rtl/drive_cmd_arbiter_if.sv - command, sensor and drive-output bundle for the drive arbiter
`timescale 1ns/1ps
interface drive_cmd_arbiter_if #(
  parameter int SPEED_W = 8,
  parameter int DEG_W   = 9,
  parameter int N_TRACK = 4
);
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic [SPEED_W-1:0] button;
  logic [7:0]         forward_dist;
  logic [N_TRACK-1:0] track;
  logic [SPEED_W-1:0] speed;
  logic [DEG_W-1:0]   degree;
  logic               direction;
  logic               beep_en;
  logic [1:0]         mode;
  logic               timeout;
  logic               obstacle;

  modport master (
    output rx_valid, rx_data, button, forward_dist, track,
    input  speed, degree, direction, beep_en, mode, timeout, obstacle
  );

  modport slave (
    input  rx_valid, rx_data, button, forward_dist, track,
    output speed, degree, direction, beep_en, mode, timeout, obstacle
  );
endinterface

// File: rtl/drive_cmd_arbiter.sv
// rtl/drive_cmd_arbiter.sv - Zigbee command decode, speed slew, reversal interlock, obstacle stop and watchdog
`timescale 1ns/1ps
module drive_cmd_arbiter #(
  parameter int SPEED_W     = 8,
  parameter int DEG_W       = 9,
  parameter int DEG_CENTER  = 95,
  parameter int DEG_LEFT    = 60,
  parameter int DEG_RIGHT   = 120,
  parameter int N_TRACK     = 4,
  parameter int SAFE_DIST   = 20,
  parameter int RAMP_DIV    = 500000,
  parameter int RAMP_STEP   = 1,
  parameter int TIMEOUT_CYC = 25000000
) (
  input logic clk_50M,
  input logic rst_n,
  drive_cmd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {M_IDLE = 2'd0, M_REMOTE = 2'd1, M_TRACK = 2'd2, M_ROAM = 2'd3} mode_t;

  localparam int PW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int WW       = $clog2(TIMEOUT_CYC + 1);
  localparam int DEG_STEP = (DEG_RIGHT - DEG_LEFT) / (N_TRACK - 1);
  localparam logic [SPEED_W-1:0] STEP     = SPEED_W'(RAMP_STEP);
  localparam logic [DEG_W-1:0]   D_CENTER = DEG_W'(DEG_CENTER);
  localparam logic [DEG_W-1:0]   D_LEFT   = DEG_W'(DEG_LEFT);
  localparam logic [DEG_W-1:0]   D_RIGHT  = DEG_W'(DEG_RIGHT);

  mode_t              mode_q, mode_d;
  logic [SPEED_W-1:0] speed_q, speed_d, cruise_q, cruise_d;
  logic [DEG_W-1:0]   degree_q, degree_d, rdeg_q, rdeg_d;
  logic               dir_q, dir_d, beep_q, beep_d, timeout_q, timeout_d;
  logic               obstacle_q, obstacle_d, cset_q, cset_d, rdir_q, rdir_d;
  logic [1:0]         rcode_q, rcode_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [WW-1:0]      wd_q, wd_d;

  logic [SPEED_W-1:0] eff_cruise, target;
  logic [DEG_W-1:0]   want_deg;
  logic               tick, req_dir, obs, estop, trk_hit;
  int                 trk_idx;

  always_comb begin
    mode_d     = mode_q;
    speed_d    = speed_q;
    cruise_d   = cruise_q;
    degree_d   = degree_q;
    rdeg_d     = rdeg_q;
    dir_d      = dir_q;
    timeout_d  = timeout_q;
    cset_d     = cset_q;
    rdir_d     = rdir_q;
    rcode_d    = rcode_q;
    wd_d       = wd_q;
    eff_cruise = cset_q ? cruise_q : bus.button;
    tick       = (presc_q == PW'(RAMP_DIV - 1));
    presc_d    = tick ? '0 : presc_q + PW'(1);
    target     = '0;
    want_deg   = D_CENTER;
    req_dir    = 1'b1;
    trk_hit    = 1'b0;
    trk_idx    = 0;

    for (int i = N_TRACK - 1; i >= 0; i--) begin
      if (bus.track[i]) begin
        trk_hit = 1'b1;
        trk_idx = i;
      end
    end

    case (mode_q)
      M_IDLE: req_dir = dir_q;
      M_REMOTE: begin
        target   = (rcode_q == 2'b10) ? eff_cruise :
                   (rcode_q == 2'b01) ? (eff_cruise >> 1) : '0;
        want_deg = rdeg_q;
        req_dir  = rdir_q;
      end
      M_TRACK: begin
        if (&bus.track) begin
          want_deg = degree_q;
        end else begin
          target   = eff_cruise;
          want_deg = trk_hit ? DEG_W'(DEG_LEFT + trk_idx * DEG_STEP) : D_CENTER;
        end
      end
      default: target = eff_cruise;
    endcase

    // A pending reversal drives the ramp to zero before the flip.
    if (req_dir != dir_q) target = '0;

    obs   = dir_q && (bus.forward_dist <= 8'(SAFE_DIST));
    estop = bus.rx_valid && (bus.rx_data[7:6] == 2'b11);

    if (estop || obs) begin
      speed_d = '0;
    end else if (tick) begin
      if (speed_q < target)
        speed_d = (target - speed_q > STEP) ? speed_q + STEP : target;
      else if (speed_q > target)
        speed_d = (speed_q - target > STEP) ? speed_q - STEP : target;
    end
    if (req_dir != dir_q && speed_q == '0) dir_d = req_dir;

    if (bus.rx_valid) begin
      wd_d      = '0;
      timeout_d = 1'b0;
      case (bus.rx_data[7:6])
        2'b00: begin
          mode_d  = M_REMOTE;
          rcode_d = bus.rx_data[1:0];
          rdir_d  = ~bus.rx_data[4];
          rdeg_d  = (bus.rx_data[3:2] == 2'b01) ? D_LEFT :
                    (bus.rx_data[3:2] == 2'b10) ? D_RIGHT : D_CENTER;
        end
        2'b01: begin
          cruise_d = SPEED_W'(bus.rx_data[5:0]);
          cset_d   = 1'b1;
        end
        2'b10: begin
          case (bus.rx_data[1:0])
            2'b00:   mode_d = M_TRACK;
            2'b01:   mode_d = M_ROAM;
            2'b10:   mode_d = M_IDLE;
            default: mode_d = mode_q;
          endcase
        end
        default: begin
          mode_d  = M_IDLE;
          rcode_d = 2'b00;
        end
      endcase
    end else if (mode_q == M_REMOTE) begin
      if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
        mode_d    = M_IDLE;
        timeout_d = 1'b1;
        wd_d      = '0;
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end else begin
      wd_d = '0;
    end

    degree_d   = want_deg;
    obstacle_d = obs;
    beep_d     = obs | (~dir_d & (speed_d != '0));
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      mode_q     <= M_IDLE;
      speed_q    <= '0;
      cruise_q   <= '0;
      degree_q   <= D_CENTER;
      rdeg_q     <= D_CENTER;
      dir_q      <= 1'b1;
      beep_q     <= 1'b0;
      timeout_q  <= 1'b0;
      obstacle_q <= 1'b0;
      cset_q     <= 1'b0;
      rdir_q     <= 1'b1;
      rcode_q    <= 2'b00;
      presc_q    <= '0;
      wd_q       <= '0;
    end else begin
      mode_q     <= mode_d;
      speed_q    <= speed_d;
      cruise_q   <= cruise_d;
      degree_q   <= degree_d;
      rdeg_q     <= rdeg_d;
      dir_q      <= dir_d;
      beep_q     <= beep_d;
      timeout_q  <= timeout_d;
      obstacle_q <= obstacle_d;
      cset_q     <= cset_d;
      rdir_q     <= rdir_d;
      rcode_q    <= rcode_d;
      presc_q    <= presc_d;
      wd_q       <= wd_d;
    end
  end

  assign bus.speed     = speed_q;
  assign bus.degree    = degree_q;
  assign bus.direction = dir_q;
  assign bus.beep_en   = beep_q;
  assign bus.mode      = mode_q;
  assign bus.timeout   = timeout_q;
  assign bus.obstacle  = obstacle_q;
endmodule
